// File: rtl/irq_pkg.sv
// Shared constants, FSM states and helpers for the
// eight-line interrupt vector controller.
package irq_pkg;

    localparam int N_IRQ = 8;
    localparam int VEC_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Index of the most significant set bit; 0 when none are set.
    function automatic logic [VEC_W-1:0] highest_set(
        input logic [N_IRQ-1:0] d
    );
        logic [VEC_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (d[i]) r = VEC_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_encode8.sv
// Combinational 8-to-3 priority encoder, bit 7 highest,
// with an any-valid flag.
module prio_encode8
    import irq_pkg::*;
(
    input  logic [N_IRQ-1:0] req,
    output logic [VEC_W-1:0] idx,
    output logic             any
);

    assign idx = highest_set(req);
    assign any = |req;

endmodule

// File: rtl/irq_vector_ctrl8.sv
// Eight-line interrupt controller: sync, pending latch,
// mask/nesting filter and vector offer over valid/ready.
module irq_vector_ctrl8
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit LEVEL_MODE  = 1'b0
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] mask,
    output logic             vec_valid,
    output logic [VEC_W-1:0] vec,
    input  logic             vec_ready,
    input  logic             eoi,
    input  logic [VEC_W-1:0] eoi_id,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service,
    output logic             lost
);

    logic [N_IRQ-1:0] irq_s;
    logic [N_IRQ-1:0] prev;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] xfer_clr;
    logic [N_IRQ-1:0] eoi_clr;
    logic [N_IRQ-1:0] above;
    logic [N_IRQ-1:0] elig;
    logic [N_IRQ-1:0] pend_n;
    logic [N_IRQ-1:0] isr_n;
    logic [VEC_W-1:0] elig_idx;
    logic [VEC_W-1:0] isr_idx;
    logic [VEC_W-1:0] vec_n;
    logic             elig_any;
    logic             isr_any;
    logic             valid_n;
    logic             lost_n;
    logic             xfer;
    state_t           state;
    state_t           state_n;

    genvar s;
    for (s = 0; s < SYNC_STAGES; s++) begin : g_sync
        logic [N_IRQ-1:0] q;
        if (s == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) q <= '0;
                else        q <= irq_in;
            end
        end else begin : g_next
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) q <= '0;
                else        q <= g_sync[s-1].q;
            end
        end
    end

    assign irq_s = g_sync[SYNC_STAGES-1].q;
    assign rise  = irq_s & ~prev;
    assign xfer  = vec_valid & vec_ready;

    prio_encode8 u_elig (
        .req (elig),
        .idx (elig_idx),
        .any (elig_any)
    );

    prio_encode8 u_isr (
        .req (in_service),
        .idx (isr_idx),
        .any (isr_any)
    );

    always_comb begin
        xfer_clr = '0;
        eoi_clr  = '0;
        above    = '0;
        if (xfer) xfer_clr[vec] = 1'b1;
        if (eoi)  eoi_clr[eoi_id] = 1'b1;
        // Nesting: only lines above the highest in-service one.
        for (int i = 0; i < N_IRQ; i++) begin
            above[i] = !isr_any || (i > int'(isr_idx));
        end
    end

    assign elig  = pending & ~mask & ~in_service & above;
    assign isr_n = (in_service & ~eoi_clr) | xfer_clr;

    always_comb begin
        if (LEVEL_MODE) begin
            pend_n = irq_s;
            lost_n = 1'b0;
        end else begin
            pend_n = (pending & ~xfer_clr) | rise;
            lost_n = |(rise & pending & ~xfer_clr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev       <= '0;
            pending    <= '0;
            in_service <= '0;
            lost       <= 1'b0;
        end else begin
            prev       <= irq_s;
            pending    <= pend_n;
            in_service <= isr_n;
            lost       <= lost_n;
        end
    end

    always_comb begin
        state_n = state;
        vec_n   = vec;
        valid_n = vec_valid;
        unique case (state)
            IDLE: begin
                if (elig_any) begin
                    vec_n   = elig_idx;
                    valid_n = 1'b1;
                    state_n = OFFER;
                end
            end
            OFFER: begin
                if (xfer) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                valid_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec       <= '0;
            vec_valid <= 1'b0;
        end else begin
            state     <= state_n;
            vec       <= vec_n;
            vec_valid <= valid_n;
        end
    end

endmodule

// File: tb/tb_irq_vector_ctrl8.sv
// Directed bench for irq_vector_ctrl8: edge-mode instance
// plus a level-mode instance sharing clock and reset.
module tb_irq_vector_ctrl8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_in;
    logic [7:0] mask;
    logic       vec_ready;
    logic       eoi;
    logic [2:0] eoi_id;
    logic       vec_valid;
    logic [2:0] vec;
    logic [7:0] pending;
    logic [7:0] in_service;
    logic       lost;

    logic [7:0] irq_l;
    logic       ready_l;
    logic       eoi_l;
    logic [2:0] eoi_id_l;
    logic       valid_l;
    logic [2:0] vec_l;
    logic [7:0] pend_l;
    logic [7:0] isr_l;
    logic       lost_l;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    irq_vector_ctrl8 #(.SYNC_STAGES(2), .LEVEL_MODE(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_in),
        .mask       (mask),
        .vec_valid  (vec_valid),
        .vec        (vec),
        .vec_ready  (vec_ready),
        .eoi        (eoi),
        .eoi_id     (eoi_id),
        .pending    (pending),
        .in_service (in_service),
        .lost       (lost)
    );

    irq_vector_ctrl8 #(.SYNC_STAGES(2), .LEVEL_MODE(1'b1)) u_lvl (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_l),
        .mask       (8'h00),
        .vec_valid  (valid_l),
        .vec        (vec_l),
        .vec_ready  (ready_l),
        .eoi        (eoi_l),
        .eoi_id     (eoi_id_l),
        .pending    (pend_l),
        .in_service (isr_l),
        .lost       (lost_l)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_eoi(input logic [2:0] id);
        eoi    = 1'b1;
        eoi_id = id;
        step(1);
        eoi    = 1'b0;
    endtask

    task automatic xfer;
        vec_ready = 1'b1;
        step(1);
        vec_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq_in = '0; mask = '0;
        vec_ready = 1'b0; eoi = 1'b0; eoi_id = '0;
        irq_l = '0; ready_l = 1'b0; eoi_l = 1'b0; eoi_id_l = '0;
        step(3);
        chk("rst_valid", vec_valid, 8'h0);
        chk("rst_vec", vec, 8'h0);
        chk("rst_pend", pending, 8'h00);
        chk("rst_isr", in_service, 8'h00);
        chk("rst_lost", lost, 8'h0);
        rst_n = 1'b1;
        step(2);

        // single pulse on line 3, latency check
        irq_in = 8'h08;
        step(2);
        chk("t1_pend_e1", pending, 8'h00);
        step(1);
        chk("t1_pend_e2", pending, 8'h08);
        chk("t1_valid_e2", vec_valid, 8'h0);
        step(1);
        chk("t1_valid_e3", vec_valid, 8'h1);
        chk("t1_vec", vec, 8'h3);
        irq_in = 8'h00;
        xfer();
        chk("t1_pend_x", pending, 8'h00);
        chk("t1_isr_x", in_service, 8'h08);
        chk("t1_valid_x", vec_valid, 8'h0);
        do_eoi(3'd3);
        chk("t1_isr_eoi", in_service, 8'h00);

        // lines 5 and 2 with line 5 masked
        irq_in = 8'h24; mask = 8'h20;
        step(3);
        chk("t2_pend", pending, 8'h24);
        irq_in = 8'h00;
        step(1);
        chk("t2_valid", vec_valid, 8'h1);
        chk("t2_vec", vec, 8'h2);
        xfer();
        chk("t2_pend_x", pending, 8'h20);
        chk("t2_isr_x", in_service, 8'h04);
        step(3);
        chk("t2_masked", vec_valid, 8'h0);
        chk("t2_pend_hold", pending, 8'h20);
        mask = 8'h00;
        step(1);
        chk("t2_valid5", vec_valid, 8'h1);
        chk("t2_vec5", vec, 8'h5);
        xfer();
        chk("t2_isr_x5", in_service, 8'h24);
        chk("t2_pend_x5", pending, 8'h00);
        do_eoi(3'd5);
        do_eoi(3'd2);
        chk("t2_isr_eoi", in_service, 8'h00);

        // nesting with line 4 in service
        irq_in = 8'h10;
        step(4);
        chk("t3_vec4", vec, 8'h4);
        xfer();
        irq_in = 8'h00;
        chk("t3_isr10", in_service, 8'h10);
        step(3);
        irq_in = 8'h44;
        step(4);
        chk("t3_valid6", vec_valid, 8'h1);
        chk("t3_vec6", vec, 8'h6);
        xfer();
        irq_in = 8'h00;
        chk("t3_isr50", in_service, 8'h50);
        chk("t3_pend04", pending, 8'h04);
        step(1);
        chk("t3_blocked", vec_valid, 8'h0);
        do_eoi(3'd6);
        chk("t3_isr_e6", in_service, 8'h10);
        step(1);
        chk("t3_still_blk", vec_valid, 8'h0);
        do_eoi(3'd4);
        chk("t3_isr_e4", in_service, 8'h00);
        step(1);
        chk("t3_valid2", vec_valid, 8'h1);
        chk("t3_vec2", vec, 8'h2);
        xfer();
        do_eoi(3'd2);

        // offer frozen while a higher line arrives
        irq_in = 8'h02;
        step(4);
        chk("t4_vec1", vec, 8'h1);
        irq_in = 8'h82;
        step(4);
        chk("t4_frozen_v", vec_valid, 8'h1);
        chk("t4_frozen", vec, 8'h1);
        chk("t4_pend", pending, 8'h82);
        xfer();
        irq_in = 8'h00;
        chk("t4_idle", vec_valid, 8'h0);
        chk("t4_isr", in_service, 8'h02);
        step(1);
        chk("t4_valid7", vec_valid, 8'h1);
        chk("t4_vec7", vec, 8'h7);
        xfer();
        do_eoi(3'd7);
        do_eoi(3'd1);
        chk("t4_isr_clr", in_service, 8'h00);

        // lost pulse on a re-edge of pending line 0
        mask = 8'h01;
        irq_in = 8'h01;
        step(3);
        chk("t5_pend", pending, 8'h01);
        irq_in = 8'h00;
        step(3);
        irq_in = 8'h01;
        step(2);
        chk("t5_lost_pre", lost, 8'h0);
        step(1);
        chk("t5_lost", lost, 8'h1);
        chk("t5_pend_keep", pending, 8'h01);
        step(1);
        chk("t5_lost_end", lost, 8'h0);
        irq_in = 8'h00;
        step(3);
        mask = 8'h00;
        step(1);
        chk("t5_valid0", vec_valid, 8'h1);
        chk("t5_vec0", vec, 8'h0);
        irq_in = 8'h01;
        step(2);
        xfer();
        chk("t5_coinc_pend", pending, 8'h01);
        chk("t5_coinc_lost", lost, 8'h0);
        chk("t5_coinc_isr", in_service, 8'h01);
        step(1);
        chk("t5_lost_after", lost, 8'h0);
        chk("t5_no_reoffer", vec_valid, 8'h0);
        do_eoi(3'd0);
        step(1);
        chk("t5_reoffer", vec_valid, 8'h1);
        xfer();
        chk("t5_pend_clr", pending, 8'h00);
        do_eoi(3'd0);
        irq_in = 8'h00;
        step(3);

        // async reset mid-offer, line held through release
        irq_in = 8'h08;
        step(4);
        chk("t6_valid", vec_valid, 8'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", vec_valid, 8'h0);
        chk("t6_rst_pend", pending, 8'h00);
        chk("t6_rst_isr", in_service, 8'h00);
        chk("t6_rst_vec", vec, 8'h0);
        step(2);
        rst_n = 1'b1;
        step(4);
        chk("t6_held_v", vec_valid, 8'h1);
        chk("t6_held_vec", vec, 8'h3);
        xfer();
        chk("t6_pend_x", pending, 8'h00);
        step(6);
        chk("t6_once", vec_valid, 8'h0);
        chk("t6_once_pend", pending, 8'h00);
        irq_in = 8'h00;
        do_eoi(3'd3);

        // level mode: held line re-offers only after eoi
        irq_l = 8'h20;
        step(4);
        chk("lv_valid", valid_l, 8'h1);
        chk("lv_vec", vec_l, 8'h5);
        chk("lv_pend", pend_l, 8'h20);
        ready_l = 1'b1;
        step(1);
        ready_l = 1'b0;
        chk("lv_valid_x", valid_l, 8'h0);
        chk("lv_pend_x", pend_l, 8'h20);
        chk("lv_isr_x", isr_l, 8'h20);
        step(3);
        chk("lv_blocked", valid_l, 8'h0);
        eoi_l = 1'b1; eoi_id_l = 3'd5;
        step(1);
        eoi_l = 1'b0;
        chk("lv_isr_eoi", isr_l, 8'h00);
        step(1);
        chk("lv_reoffer", valid_l, 8'h1);
        chk("lv_revec", vec_l, 8'h5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_vector_ctrl8.md
# irq_vector_ctrl8

Eight-line interrupt request controller. It synchronises and latches raw request lines into a pending register and applies a mask and in-service nesting rules. It offers the highest-priority eligible request as a 3-bit vector over a valid/ready handshake. It is the stage that collects the 8-bit request vector and produces the 3-bit priority code consumed by the dispatch logic downstream. Priority is fixed: bit 7 highest, bit 0 lowest.

## Interface
- SYNC_STAGES, 2: flip-flop synchroniser depth per request line, legal range 2..3.
- LEVEL_MODE, 0: 0 = rising-edge requests latched in pending; 1 = level-sensitive, pending mirrors the synchronised line.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- irq_in  in  8  raw request lines, asynchronous to clk.
- mask  in  8  1 = line masked; masked lines still latch pending but are never offered.
- vec_valid  out  1  vector offer valid.
- vec  out  3  offered vector index, 7 = line 7.
- vec_ready  in  1  consumer accepts; transfer on edge with vec_valid & vec_ready.
- eoi  in  1  end-of-interrupt strobe, one cycle.
- eoi_id  in  3  line index whose in-service bit eoi clears.
- pending  out  8  pending register.
- in_service  out  8  in-service register.
- lost  out  1  one-cycle pulse: an edge arrived on a line already pending (edge mode only).

## Operation
- Reset: sync chains, edge-detect history, pending, in_service, vec, vec_valid, lost all 0. State IDLE.
- Edge mode: pending[i] sets on the synchronised rising edge. It clears only on transfer of vector i.
- A line held high through reset exit produces exactly one request.
- Level mode: pending[i] = synchronised irq_in[i]. Transfer does not clear it. in_service blocks re-offer until eoi.
- Eligible set: pending & ~mask & ~in_service, restricted to lines with index greater than the highest set in_service bit. With in_service = 0, all lines qualify.
- FSM IDLE: if eligible ≠ 0, register vec = highest eligible index, set vec_valid, go to OFFER.
- FSM OFFER: vec and vec_valid stay frozen until transfer, even if a higher request arrives or the mask changes.
- On transfer: pending[vec] clears (edge mode), in_service[vec] sets, vec_valid drops, return to IDLE.
- eoi: clears in_service[eoi_id]. eoi on a bit that is not in service is ignored. eoi is honoured in any state.
- Simultaneous events on one edge:
  - New edge on line i plus transfer of i: pending[i] stays 1 and lost stays 0.
  - New edge on an already-pending line with no transfer of it: pending unchanged, lost pulses.
  - eoi plus transfer of the same index: set wins, in_service stays 1.
  - eoi and transfer on different indices: both apply.
- Asynchronous reset mid-OFFER: vec_valid drops immediately, and the vector is lost.

## Timing
- Edge 0 is the first edge sampling irq_in high, with SYNC_STAGES = 2.
- Synchronised high after edge 1.
- pending set at edge 2.
- vec_valid high after edge 3, i.e. 3 cycles of input-to-offer latency plus one per extra sync stage.
- Transfer at edge t: vec_valid low after t. The next offer can appear after edge t+1 at the earliest. Sustained throughput is one vector per 2 cycles.
- eoi at edge t: in_service updated after t. A newly eligible line can offer after edge t+1.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package irq_pkg:
  - N_IRQ = 8, VEC_W = 3.
  - State enum {IDLE, OFFER}.
  - Function highest_set(8-bit) returning a 3-bit index.
- One sub-module, prio_encode8: combinational 8→3 priority encoder with an any-valid output. It is instantiated twice: once on the eligible set, once on in_service for the nesting threshold.
- The synchroniser is an inline generate loop, not a separate module.

## Test plan
- Reset with irq_in = 8'h00, then pulse irq_in[3] high: pending = 8'h08 after edge 2, vec_valid = 1 with vec = 3 after edge 3. Assert vec_ready: pending = 0, in_service = 8'h08, vec_valid = 0.
- Edge on lines 5 and 2 together, mask = 8'h20: vec = 2 offered; pending[5] remains 1 and is never offered until the mask clears, then vec = 5.
- With in_service = 8'h10, raise lines 2 and 6: only vec = 6 is offered. After transfer and eoi with eoi_id = 6, then eoi_id = 4, vec = 2 is offered.
- During OFFER of vec = 1 with vec_ready = 0, raise line 7: vec stays 1 until transfer, then vec = 7 follows after one idle cycle.
- Second rising edge on line 0 while pending[0] = 1: lost pulses for exactly one cycle. An edge coinciding with the transfer of 0 leaves pending[0] = 1 and lost = 0.
- Drop rst_n while vec_valid = 1: all outputs 0 asynchronously. A line held high at release yields exactly one vector. In LEVEL_MODE = 1, a held line re-offers only after eoi.
